systolic_matmul_engine: RTL and testbench

//  Output-stationary SIZE x SIZE systolic matrix multiplier with its own control FSM.
//  - Captures operand matrices A and B in one valid/ready handshake.
//  - Clears the PE accumulators, then drives the skewed row and column streams.
//  - Holds the product C = A x B until the consumer accepts it.
//  - Sits between the operand buffer and the result writeback in the matmul datapath.
//  - Unlike the earlier free-running array: explicit start/done handshake, accumulator

---
 rtl/systolic_pkg.sv | 14 +
 rtl/systolic_matmul_engine_if.sv | 28 ++
 rtl/systolic_pe.sv | 83 ++++++++
 rtl/systolic_matmul_engine.sv | 114 +++++++++++
 tb/tb_systolic_matmul_engine.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/systolic_pkg.sv
// Shared types and sizing helpers for the systolic matrix multiplier.
package systolic_pkg;

    typedef enum logic [1:0] {IDLE, CLEAR, RUN, DONE} mm_state_t;

    function automatic int run_cycles(input int size);
        return 3 * size - 2;
    endfunction

    function automatic int default_acc_w(input int data_w, input int size);
        return 2 * data_w + $clog2(size);
    endfunction

endpackage

// File: rtl/systolic_matmul_engine_if.sv
// Operand/result bus of the systolic matmul engine; master = producer/consumer side, slave = engine.
interface systolic_matmul_engine_if #(
    parameter int SIZE   = 4,
    parameter int DATA_W = 4,
    parameter int ACC_W  = 2 * DATA_W + $clog2(SIZE)
);
    // Operands transfer on an edge with start && ready; the result transfers on an edge
    // with result_valid && result_ready. result stays constant while result_valid is high.
    logic                                  start;
    logic                                  ready;
    logic [SIZE-1:0][SIZE-1:0][DATA_W-1:0] a_in;
    logic [SIZE-1:0][SIZE-1:0][DATA_W-1:0] b_in;
    logic                                  abort;
    logic                                  busy;
    logic [SIZE-1:0][SIZE-1:0][ACC_W-1:0]  result;
    logic                                  result_valid;
    logic                                  result_ready;

    modport master (
        output start, a_in, b_in, abort, result_ready,
        input  ready, busy, result, result_valid
    );

    modport slave (
        input  start, a_in, b_in, abort, result_ready,
        output ready, busy, result, result_valid
    );
endinterface

// File: rtl/systolic_pe.sv
// One multiply-accumulate cell of the systolic grid; a moves right, b moves down.
// With SYSTOLIC_SATURATE_EN defined the accumulator clamps and stays clamped until clear.
module systolic_pe #(
    parameter int DATA_W = 4,
    parameter int ACC_W  = 10,
    parameter bit SIGNED = 1'b0
) (
    input  logic              clock,
    input  logic              nreset,
    input  logic              clear,
    input  logic              en,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] a_pass,
    output logic [DATA_W-1:0] b_pass,
    output logic [ACC_W-1:0]  acc
);
    logic [ACC_W-1:0] prod;
    logic [ACC_W-1:0] sum;
    logic [ACC_W-1:0] acc_next;

    generate
        if (SIGNED) begin : g_signed
            logic signed [2*DATA_W-1:0] p;
            assign p    = (2*DATA_W)'($signed(a)) * (2*DATA_W)'($signed(b));
            assign prod = ACC_W'(p);
        end else begin : g_unsigned
            logic [2*DATA_W-1:0] p;
            assign p    = (2*DATA_W)'(a) * (2*DATA_W)'(b);
            assign prod = ACC_W'(p);
        end
    endgenerate

    assign sum = acc + prod;

`ifdef SYSTOLIC_SATURATE_EN
    logic             sat_q;
    logic             ovf;
    logic [ACC_W-1:0] clamp;

    // Unsigned overflow is a wrap below the old value; signed overflow flips the sign
    // of two like-signed addends.
    always_comb begin
        ovf   = 1'b0;
        clamp = '1;
        if (SIGNED) begin
            ovf   = (acc[ACC_W-1] == prod[ACC_W-1]) && (sum[ACC_W-1] != acc[ACC_W-1]);
            clamp = acc[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        end else begin
            ovf   = (sum < acc);
        end
        acc_next = sat_q ? acc : (ovf ? clamp : sum);
    end

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            sat_q <= 1'b0;
        end else if (clear) begin
            sat_q <= 1'b0;
        end else if (en && ovf) begin
            sat_q <= 1'b1;
        end
    end
`else
    assign acc_next = sum;
`endif

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            acc    <= '0;
            a_pass <= '0;
            b_pass <= '0;
        end else if (clear) begin
            acc    <= '0;
            a_pass <= '0;
            b_pass <= '0;
        end else if (en) begin
            acc    <= acc_next;
            a_pass <= a;
            b_pass <= b;
        end
    end
endmodule

// File: rtl/systolic_matmul_engine.sv
// Output-stationary SIZE x SIZE systolic matmul with IDLE/CLEAR/RUN/DONE control.
// Optional build macro SYSTOLIC_SATURATE_EN makes every accumulator saturate.
module systolic_matmul_engine
    import systolic_pkg::*;
#(
    parameter int SIZE   = 4,
    parameter int DATA_W = 4,
    parameter int ACC_W  = default_acc_w(DATA_W, SIZE),
    parameter bit SIGNED = 1'b0
) (
    input  logic                    clock,
    input  logic                    nreset,
    systolic_matmul_engine_if.slave bus,
    output mm_state_t               fsm_state
);
    localparam int LAST  = run_cycles(SIZE) - 1;
    localparam int CNT_W = $clog2(LAST + 1);

    mm_state_t                             state;
    mm_state_t                             state_next;
    logic [CNT_W-1:0]                      cnt;
    logic                                  valid_q;
    logic [SIZE-1:0][SIZE-1:0][DATA_W-1:0] a_q;
    logic [SIZE-1:0][SIZE-1:0][DATA_W-1:0] b_q;
    logic [SIZE-1:0][SIZE-1:0][ACC_W-1:0]  result_q;
    logic [SIZE-1:0][SIZE-1:0][ACC_W-1:0]  acc_grid;
    logic [SIZE-1:0][DATA_W-1:0]           a_feed;
    logic [SIZE-1:0][DATA_W-1:0]           b_feed;
    logic [DATA_W-1:0]                     a_grid [SIZE][SIZE+1];
    logic [DATA_W-1:0]                     b_grid [SIZE+1][SIZE];

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (bus.start) state_next = CLEAR;
            CLEAR:   state_next = bus.abort ? IDLE : RUN;
            RUN: begin
                if (bus.abort)                    state_next = IDLE;
                else if (cnt == CNT_W'(LAST))     state_next = DONE;
            end
            DONE:    if (bus.abort || (valid_q && bus.result_ready)) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Result is snapshotted on the first DONE cycle, so valid appears one edge into DONE.
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            state    <= IDLE;
            cnt      <= '0;
            valid_q  <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
        end else begin
            state   <= state_next;
            cnt     <= (state == RUN && state_next == RUN) ? cnt + CNT_W'(1) : '0;
            valid_q <= (state == DONE) && (state_next == DONE);
            if (state == IDLE && bus.start) begin
                a_q <= bus.a_in;
                b_q <= bus.b_in;
            end
            if (state == DONE && !valid_q) result_q <= acc_grid;
        end
    end

    // Row i sees A[i][k] and column j sees B[k][j] when cnt equals the line index plus k.
    always_comb begin
        a_feed = '0;
        b_feed = '0;
        if (state == RUN) begin
            for (int i = 0; i < SIZE; i++) begin
                for (int k = 0; k < SIZE; k++) begin
                    if (cnt == CNT_W'(i + k)) begin
                        a_feed[i] = a_q[i][k];
                        b_feed[i] = b_q[k][i];
                    end
                end
            end
        end
    end

    generate
        for (genvar i = 0; i < SIZE; i++) begin : g_edge
            assign a_grid[i][0] = a_feed[i];
            assign b_grid[0][i] = b_feed[i];
        end
        for (genvar i = 0; i < SIZE; i++) begin : g_row
            for (genvar j = 0; j < SIZE; j++) begin : g_col
                systolic_pe #(
                    .DATA_W (DATA_W),
                    .ACC_W  (ACC_W),
                    .SIGNED (SIGNED)
                ) u_pe (
                    .clock  (clock),
                    .nreset (nreset),
                    .clear  (state == CLEAR),
                    .en     (state == RUN),
                    .a      (a_grid[i][j]),
                    .b      (b_grid[i][j]),
                    .a_pass (a_grid[i][j+1]),
                    .b_pass (b_grid[i+1][j]),
                    .acc    (acc_grid[i][j])
                );
            end
        end
    endgenerate

    assign bus.ready        = (state == IDLE);
    assign bus.busy         = (state != IDLE);
    assign bus.result_valid = valid_q;
    assign bus.result       = result_q;
    assign fsm_state        = state;
endmodule

// File: tb/tb_systolic_matmul_engine.sv
// Bench for systolic_matmul_engine: unsigned, signed and narrow-accumulator builds in lockstep.
module tb_systolic_matmul_engine;
    import systolic_pkg::*;

    typedef logic [3:0][3:0][3:0] mat_t;
    typedef logic [3:0][3:0][9:0] res_t;
    typedef logic [3:0][3:0][7:0] res8_t;
    typedef struct {
        mat_t  a;
        mat_t  b;
        res_t  exp_u;
        res_t  exp_s;
        res8_t exp_n;
    } vec_t;

    logic clock = 1'b0;
    logic nreset = 1'b0;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic result_ready = 1'b0;
    mat_t a_drv = '0;
    mat_t b_drv = '0;
    mm_state_t state_u, state_s, state_n;

    int checks = 0;
    int errors = 0;
    logic [159:0] exp_q [$];
    vec_t vecs [9];

    always #5 clock = ~clock;

    systolic_matmul_engine_if #(.SIZE(4), .DATA_W(4), .ACC_W(10)) bus_u ();
    systolic_matmul_engine_if #(.SIZE(4), .DATA_W(4), .ACC_W(10)) bus_s ();
    systolic_matmul_engine_if #(.SIZE(4), .DATA_W(4), .ACC_W(8))  bus_n ();

    assign bus_u.start = start;  assign bus_s.start = start;  assign bus_n.start = start;
    assign bus_u.abort = abort;  assign bus_s.abort = abort;  assign bus_n.abort = abort;
    assign bus_u.a_in  = a_drv;  assign bus_s.a_in  = a_drv;  assign bus_n.a_in  = a_drv;
    assign bus_u.b_in  = b_drv;  assign bus_s.b_in  = b_drv;  assign bus_n.b_in  = b_drv;
    assign bus_u.result_ready = result_ready;
    assign bus_s.result_ready = result_ready;
    assign bus_n.result_ready = result_ready;

    systolic_matmul_engine #(.SIZE(4), .DATA_W(4), .SIGNED(1'b0)) dut_u (
        .clock(clock), .nreset(nreset), .bus(bus_u), .fsm_state(state_u));
    systolic_matmul_engine #(.SIZE(4), .DATA_W(4), .SIGNED(1'b1)) dut_s (
        .clock(clock), .nreset(nreset), .bus(bus_s), .fsm_state(state_s));
    systolic_matmul_engine #(.SIZE(4), .DATA_W(4), .ACC_W(8), .SIGNED(1'b0)) dut_n (
        .clock(clock), .nreset(nreset), .bus(bus_n), .fsm_state(state_n));

    // Reference: plain dot products, then reduced to each build's result width.
    function automatic void model(input mat_t a, input mat_t b,
                                  output res_t u, output res_t s, output res8_t n);
        int su, ss;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                su = 0;
                ss = 0;
                for (int k = 0; k < 4; k++) begin
                    su += int'(a[i][k]) * int'(b[k][j]);
                    ss += int'($signed(a[i][k])) * int'($signed(b[k][j]));
                end
                u[i][j] = 10'(su);
                s[i][j] = 10'(ss);
`ifdef SYSTOLIC_SATURATE_EN
                n[i][j] = (su > 255) ? 8'd255 : 8'(su);
`else
                n[i][j] = 8'(su);
`endif
            end
        end
    endfunction

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic launch(input int idx, input bit with_abort);
        check("ready_before_start", bus_u.ready, 1'b1);
        a_drv = vecs[idx].a;
        b_drv = vecs[idx].b;
        start = 1'b1;
        abort = with_abort;
        result_ready = 1'b0;
        exp_q.push_back(vecs[idx].exp_u);
        tick();
        start = 1'b0;
        abort = 1'b0;
        check("busy_after_accept", bus_u.busy, 1'b1);
    endtask

    task automatic wait_and_check(input int idx);
        int lat;
        logic [159:0] e;
        lat = 0;
        while (!bus_u.result_valid && lat < 40) begin
            tick();
            lat++;
        end
        check("latency", lat, 12);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        check("result_unsigned", bus_u.result, e);
        check("result_signed", bus_s.result, vecs[idx].exp_s);
        check("result_narrow", bus_n.result, vecs[idx].exp_n);
    endtask

    task automatic accept();
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
        check("valid_drop_on_accept", bus_u.result_valid, 1'b0);
        check("ready_after_accept", bus_u.ready, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        res_t u_tmp, s_tmp;
        res8_t n_tmp;
        bit seen_valid;

        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                vecs[0].a[r][c] = (r == c) ? 4'd1 : 4'd0;
                vecs[0].b[r][c] = 4'(r * 4 + c);
                vecs[0].exp_u[r][c] = 10'(r * 4 + c);
                vecs[0].exp_n[r][c] = 8'(r * 4 + c);
                vecs[1].exp_u[r][c] = 10'd900;
                vecs[1].exp_s[r][c] = 10'd4;
`ifdef SYSTOLIC_SATURATE_EN
                vecs[1].exp_n[r][c] = 8'd255;
`else
                vecs[1].exp_n[r][c] = 8'd132;
`endif
                vecs[2].a[r][c] = 4'h8;
                vecs[2].b[r][c] = 4'h7;
                vecs[2].exp_u[r][c] = 10'd224;
                vecs[2].exp_s[r][c] = 10'(-224);
                vecs[2].exp_n[r][c] = 8'd224;
            end
        end
        model(vecs[0].a, vecs[0].b, u_tmp, s_tmp, n_tmp);
        vecs[0].exp_s = s_tmp;
        vecs[1].a = '1;
        vecs[1].b = '1;
        for (int v = 3; v < 9; v++) begin
            vecs[v].a = {$urandom, $urandom};
            vecs[v].b = {$urandom, $urandom};
            model(vecs[v].a, vecs[v].b, u_tmp, s_tmp, n_tmp);
            vecs[v].exp_u = u_tmp;
            vecs[v].exp_s = s_tmp;
            vecs[v].exp_n = n_tmp;
        end

        repeat (3) @(posedge clock);
        #1 nreset = 1'b1;
        tick();
        check("reset_ready", bus_u.ready, 1'b1);
        check("reset_busy", bus_u.busy, 1'b0);
        check("reset_valid", bus_u.result_valid, 1'b0);
        check("reset_result", bus_u.result, '0);
        check("reset_state", state_u, IDLE);

        for (int v = 0; v < 5; v++) begin
            launch(v, 1'b0);
            wait_and_check(v);
            if (v == 4) begin
                for (int c = 0; c < 5; c++) begin
                    start = 1'b1;
                    a_drv = {$urandom, $urandom};
                    b_drv = {$urandom, $urandom};
                    tick();
                    check("hold_result", bus_u.result, vecs[4].exp_u);
                    check("hold_valid", bus_u.result_valid, 1'b1);
                    check("hold_ready", bus_u.ready, 1'b0);
                end
                start = 1'b0;
            end
            accept();
        end

        launch(5, 1'b0);
        wait_and_check(5);
        result_ready = 1'b1;
        start = 1'b1;
        a_drv = vecs[6].a;
        b_drv = vecs[6].b;
        exp_q.push_back(vecs[6].exp_u);
        tick();
        result_ready = 1'b0;
        check("b2b_ready", bus_u.ready, 1'b1);
        check("b2b_not_queued", bus_u.busy, 1'b0);
        tick();
        start = 1'b0;
        wait_and_check(6);
        accept();

        launch(7, 1'b1);
        wait_and_check(7);
        accept();

        launch(8, 1'b0);
        repeat (4) tick();
        check("abort_in_run", state_u, RUN);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        exp_q.delete();
        check("abort_ready", bus_u.ready, 1'b1);
        check("abort_busy", bus_u.busy, 1'b0);
        seen_valid = 1'b0;
        for (int c = 0; c < 15; c++) begin
            tick();
            if (bus_u.result_valid) seen_valid = 1'b1;
        end
        check("abort_no_valid", seen_valid, 1'b0);

        launch(3, 1'b0);
        wait_and_check(3);
        abort = 1'b1;
        result_ready = 1'b1;
        tick();
        abort = 1'b0;
        result_ready = 1'b0;
        check("abort_done_valid", bus_u.result_valid, 1'b0);
        check("abort_done_ready", bus_u.ready, 1'b1);

        launch(2, 1'b0);
        repeat (5) tick();
        #2 nreset = 1'b0;
        #1;
        check("rst_mid_result", bus_u.result, '0);
        check("rst_mid_valid", bus_u.result_valid, 1'b0);
        check("rst_mid_busy", bus_u.busy, 1'b0);
        check("rst_mid_result_s", bus_s.result, '0);
        exp_q.delete();
        @(negedge clock);
        nreset = 1'b1;
        tick();
        launch(8, 1'b0);
        wait_and_check(8);
        accept();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
